lc2k_reg_file: RTL and testbench

//  Parametrised LC2K architectural register file: 2 async read ports, 1 sync write port with

---
 rtl/lc2k_pkg.sv | 13 +
 rtl/lc2k_rf_dump_ctrl.sv | 65 ++++++
 rtl/lc2k_reg_file.sv | 91 +++++++++
 tb/tb_lc2k_reg_file.sv | 231 +++++++++++++++++++++++
 4 files changed

// File: rtl/lc2k_pkg.sv
// Shared types and LC2K default geometry for the architectural register file.
package lc2k_pkg;

  typedef enum logic [1:0] {
    ST_INIT = 2'd0,
    ST_IDLE = 2'd1,
    ST_DUMP = 2'd2
  } rf_state_e;

  localparam int LC2K_DATA_W = 32;
  localparam int LC2K_ADDR_W = 3;

endpackage

// File: rtl/lc2k_rf_dump_ctrl.sv
// Register-file control FSM: post-reset INIT hold-off, IDLE, and the handshaked dump walk.
module lc2k_rf_dump_ctrl
  import lc2k_pkg::*;
#(
  parameter int ADDR_W = LC2K_ADDR_W
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              init_done,
  input  logic              dump_req,
  input  logic              dump_ready,
  output rf_state_e         state,
  output logic              dump_valid,
  output logic [ADDR_W-1:0] dump_idx,
  output logic              dump_last
);

  localparam int NUM_REGS = 1 << ADDR_W;
  localparam logic [ADDR_W-1:0] LAST_IDX = ADDR_W'(NUM_REGS - 1);

  rf_state_e         state_nxt;
  logic [ADDR_W-1:0] idx_nxt;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state    <= ST_INIT;
      dump_idx <= '0;
    end else begin
      state    <= state_nxt;
      dump_idx <= idx_nxt;
    end
  end

  always_comb begin
    state_nxt  = state;
    idx_nxt    = dump_idx;
    dump_valid = 1'b0;
    dump_last  = 1'b0;
    case (state)
      ST_INIT: begin
        if (init_done) state_nxt = ST_IDLE;
      end
      ST_IDLE: begin
        if (dump_req) begin
          state_nxt = ST_DUMP;
          idx_nxt   = '0;
        end
      end
      ST_DUMP: begin
        dump_valid = 1'b1;
        dump_last  = (dump_idx == LAST_IDX);
        // The index saturates at the last register; leaving DUMP is the only exit.
        if (dump_ready) begin
          if (dump_last) state_nxt = ST_IDLE;
          else           idx_nxt   = dump_idx + ADDR_W'(1);
        end
      end
      default: begin
        state_nxt = ST_INIT;
        idx_nxt   = '0;
      end
    endcase
  end

endmodule

// File: rtl/lc2k_reg_file.sv
// LC2K register file: two async read ports with write-through bypass, one sync write port,
// a post-reset init sequencer and a handshaked full-register dump port.
module lc2k_reg_file
  import lc2k_pkg::*;
#(
  parameter int DATA_W    = LC2K_DATA_W,
  parameter int ADDR_W    = LC2K_ADDR_W,
  parameter int INIT_MODE = 0,
  parameter int ZERO_REG  = 0
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [ADDR_W-1:0] rd_a_addr,
  output logic [DATA_W-1:0] rd_a_data,
  input  logic [ADDR_W-1:0] rd_b_addr,
  output logic [DATA_W-1:0] rd_b_data,
  input  logic              wr_en,
  input  logic [ADDR_W-1:0] wr_addr,
  input  logic [DATA_W-1:0] wr_data,
  output logic              init_busy,
  input  logic              dump_req,
  output logic              dump_valid,
  input  logic              dump_ready,
  output logic [ADDR_W-1:0] dump_idx,
  output logic [DATA_W-1:0] dump_data,
  output logic              dump_last
);

  localparam int NUM_REGS = 1 << ADDR_W;
  localparam logic [ADDR_W-1:0] LAST_IDX = ADDR_W'(NUM_REGS - 1);

  logic [DATA_W-1:0] mem [NUM_REGS];
  rf_state_e         state;
  logic [ADDR_W-1:0] init_idx;
  logic [DATA_W-1:0] init_val;
  logic              in_init;
  logic              init_done;
  logic              wr_live;

  function automatic logic is_zero_reg(input logic [ADDR_W-1:0] addr);
    return (ZERO_REG != 0) && (addr == '0);
  endfunction

  function automatic logic [DATA_W-1:0] rf_sel(input logic              blank,
                                               input logic              hit,
                                               input logic [DATA_W-1:0] byp,
                                               input logic [DATA_W-1:0] arr);
    return blank ? '0 : (hit ? byp : arr);
  endfunction

  assign in_init   = (state == ST_INIT);
  assign init_busy = in_init;
  assign init_done = in_init && (init_idx == LAST_IDX);
  assign init_val  = (INIT_MODE != 0) ? DATA_W'(init_idx) : '0;
  assign wr_live   = wr_en && !in_init && !is_zero_reg(wr_addr);

  always_ff @(posedge clk) begin
    if (!rst_n)         init_idx <= '0;
    else if (in_init)   init_idx <= (init_idx == LAST_IDX) ? '0 : init_idx + ADDR_W'(1);
  end

  // Array carries no reset; the init sequencer rewrites every entry after each reset.
  always_ff @(posedge clk) begin
    if (rst_n) begin
      if (in_init)      mem[init_idx] <= init_val;
      else if (wr_live) mem[wr_addr]  <= wr_data;
    end
  end

  assign rd_a_data = rf_sel(in_init || is_zero_reg(rd_a_addr),
                            wr_live && (wr_addr == rd_a_addr), wr_data, mem[rd_a_addr]);
  assign rd_b_data = rf_sel(in_init || is_zero_reg(rd_b_addr),
                            wr_live && (wr_addr == rd_b_addr), wr_data, mem[rd_b_addr]);
  assign dump_data = rf_sel(!dump_valid || is_zero_reg(dump_idx),
                            wr_live && (wr_addr == dump_idx), wr_data, mem[dump_idx]);

  lc2k_rf_dump_ctrl #(
    .ADDR_W(ADDR_W)
  ) u_dump_ctrl (
    .clk       (clk),
    .rst_n     (rst_n),
    .init_done (init_done),
    .dump_req  (dump_req),
    .dump_ready(dump_ready),
    .state     (state),
    .dump_valid(dump_valid),
    .dump_idx  (dump_idx),
    .dump_last (dump_last)
  );

endmodule

// File: tb/tb_lc2k_reg_file.sv
// Scoreboard bench for lc2k_reg_file (INIT_MODE=1, ZERO_REG=1, 8 x 32-bit registers).
module tb_lc2k_reg_file;

  localparam int SEL_RDA  = 0;
  localparam int SEL_RDB  = 1;
  localparam int SEL_BUSY = 2;
  localparam int SEL_DV   = 3;
  localparam int SEL_DD   = 4;
  localparam int SEL_DI   = 5;
  localparam int SEL_DL   = 6;

  typedef struct {
    int          sel;
    logic [31:0] exp;
    string       name;
  } chk_t;

  typedef struct {
    logic [2:0]  idx;
    logic [31:0] data;
    logic        last;
  } beat_t;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [2:0]  rd_a_addr, rd_b_addr, wr_addr, dump_idx;
  logic [31:0] rd_a_data, rd_b_data, wr_data, dump_data;
  logic        wr_en, init_busy, dump_req, dump_valid, dump_ready, dump_last;

  chk_t        chk_q[$];
  beat_t       dump_q[$];
  logic [31:0] mdl [8];
  int          tests = 0;
  int          fails = 0;

  always #5 clk = ~clk;

  lc2k_reg_file #(
    .DATA_W(32), .ADDR_W(3), .INIT_MODE(1), .ZERO_REG(1)
  ) dut (
    .clk(clk), .rst_n(rst_n),
    .rd_a_addr(rd_a_addr), .rd_a_data(rd_a_data),
    .rd_b_addr(rd_b_addr), .rd_b_data(rd_b_data),
    .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
    .init_busy(init_busy),
    .dump_req(dump_req), .dump_valid(dump_valid), .dump_ready(dump_ready),
    .dump_idx(dump_idx), .dump_data(dump_data), .dump_last(dump_last)
  );

  function automatic logic [31:0] pick(input int sel);
    case (sel)
      SEL_RDA:  return rd_a_data;
      SEL_RDB:  return rd_b_data;
      SEL_BUSY: return {31'd0, init_busy};
      SEL_DV:   return {31'd0, dump_valid};
      SEL_DD:   return dump_data;
      SEL_DI:   return {29'd0, dump_idx};
      default:  return {31'd0, dump_last};
    endcase
  endfunction

  // Monitor: drains level checks every cycle, pops a dump beat on each handshake.
  always @(negedge clk) begin
    chk_t        c;
    beat_t       b;
    logic [31:0] act;
    while (chk_q.size() > 0) begin
      c   = chk_q.pop_front();
      act = pick(c.sel);
      tests++;
      if (act !== c.exp) begin
        fails++;
        $display("FAIL %s: got %h want %h", c.name, act, c.exp);
      end
    end
    if (dump_valid === 1'b1 && dump_ready === 1'b1) begin
      tests++;
      if (dump_q.size() == 0) begin
        fails++;
        $display("FAIL dump_extra_beat: got idx %0d want no beat", dump_idx);
      end else begin
        b = dump_q.pop_front();
        if (dump_idx !== b.idx || dump_data !== b.data || dump_last !== b.last) begin
          fails++;
          $display("FAIL dump_beat: got idx %0d data %h last %b want idx %0d data %h last %b",
                   dump_idx, dump_data, dump_last, b.idx, b.data, b.last);
        end
      end
    end
  end

  task automatic want(input int sel, input string name, input logic [31:0] v);
    chk_t c;
    c.sel = sel; c.exp = v; c.name = name;
    chk_q.push_back(c);
  endtask

  task automatic push_beat(input int i);
    beat_t b;
    b.idx  = 3'(i);
    b.data = (i == 0) ? 32'd0 : mdl[i];
    b.last = (i == 7);
    dump_q.push_back(b);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Caller has just raised rst_n in the first post-reset window.
  task automatic init_phase();
    wr_en = 1'b1; wr_addr = 3'd5; wr_data = 32'h99; dump_req = 1'b1; rd_a_addr = 3'd5;
    for (int i = 0; i < 8; i++) begin
      if (i == 7) begin wr_en = 1'b0; dump_req = 1'b0; end
      want(SEL_BUSY, "init_busy_high", 32'd1);
      want(SEL_RDA, "rd_a_during_init", 32'd0);
      want(SEL_DV, "dump_valid_during_init", 32'd0);
      tick();
    end
    want(SEL_BUSY, "init_busy_low", 32'd0);
    want(SEL_DV, "dump_valid_after_init", 32'd0);
    for (int i = 0; i < 8; i++) mdl[i] = 32'(i);
  endtask

  initial begin
    bit done;
    rst_n = 1'b0; rd_a_addr = '0; rd_b_addr = '0; wr_en = 1'b0; wr_addr = '0;
    wr_data = '0; dump_req = 1'b0; dump_ready = 1'b0;
    tick(); tick();
    want(SEL_BUSY, "rst_init_busy", 32'd1);
    want(SEL_DV, "rst_dump_valid", 32'd0);
    want(SEL_DL, "rst_dump_last", 32'd0);
    want(SEL_DI, "rst_dump_idx", 32'd0);
    want(SEL_RDA, "rst_rd_a", 32'd0);
    want(SEL_RDB, "rst_rd_b", 32'd0);
    want(SEL_DD, "rst_dump_data", 32'd0);
    tick();

    rst_n = 1'b1;
    init_phase();
    rd_a_addr = 3'd5; rd_b_addr = 3'd7;
    want(SEL_RDA, "init_reg5", 32'd5);
    want(SEL_RDB, "init_reg7", 32'd7);

    tick();
    wr_en = 1'b1; wr_addr = 3'd3; wr_data = 32'hDEADBEEF; rd_a_addr = 3'd3; rd_b_addr = 3'd6;
    want(SEL_RDA, "bypass_reg3", 32'hDEADBEEF);
    want(SEL_RDB, "no_bypass_reg6", 32'd6);
    tick();
    wr_en = 1'b0; mdl[3] = 32'hDEADBEEF;
    want(SEL_RDA, "array_reg3", 32'hDEADBEEF);

    tick();
    wr_en = 1'b1; wr_addr = 3'd0; wr_data = 32'h55; rd_a_addr = 3'd0; rd_b_addr = 3'd0;
    want(SEL_RDB, "zero_reg_same_cycle", 32'd0);
    want(SEL_RDA, "zero_reg_rd_a", 32'd0);
    tick();
    wr_en = 1'b0;
    want(SEL_RDB, "zero_reg_next_cycle", 32'd0);

    tick();
    wr_en = 1'b1; wr_addr = 3'd7; wr_data = 32'h12345678; rd_a_addr = 3'd7;
    want(SEL_RDA, "bypass_reg7", 32'h12345678);
    tick();
    wr_en = 1'b0; mdl[7] = 32'h12345678;

    // Full dump with ready toggling every cycle.
    dump_req = 1'b1; dump_ready = 1'b0;
    for (int i = 0; i < 8; i++) push_beat(i);
    done = 1'b0;
    for (int k = 0; k < 40; k++) begin
      tick();
      dump_req = 1'b0;
      if (dump_q.size() == 0) begin done = 1'b1; break; end
      dump_ready = ~dump_ready;
    end
    if (!done) begin
      tests++; fails++;
      $display("FAIL dump_complete: got %0d beats outstanding want 0", dump_q.size());
    end
    dump_ready = 1'b0;
    want(SEL_DV, "dump_valid_after_last", 32'd0);
    want(SEL_DL, "dump_last_after_last", 32'd0);

    // Second dump: stall at idx 2, write through, then reset at idx 4.
    tick();
    dump_req = 1'b1;
    tick();
    dump_req = 1'b0; dump_ready = 1'b1; push_beat(0);
    tick();
    push_beat(1);
    tick();
    dump_ready = 1'b0; wr_en = 1'b1; wr_addr = 3'd2; wr_data = 32'hA5;
    want(SEL_DI, "stall_idx2", 32'd2);
    want(SEL_DD, "stall_bypass_data", 32'hA5);
    tick();
    wr_en = 1'b0; mdl[2] = 32'hA5;
    want(SEL_DI, "stall_idx2_held", 32'd2);
    want(SEL_DD, "stall_array_data", 32'hA5);
    tick();
    dump_ready = 1'b1; push_beat(2);
    tick();
    push_beat(3);
    tick();
    dump_ready = 1'b0;
    want(SEL_DI, "stall_idx4", 32'd4);
    want(SEL_DV, "dumping_idx4", 32'd1);
    want(SEL_DL, "not_last_idx4", 32'd0);
    rst_n = 1'b0;
    tick();
    want(SEL_DV, "abort_dump_valid", 32'd0);
    want(SEL_DI, "abort_dump_idx", 32'd0);
    rst_n = 1'b1;
    init_phase();
    rd_a_addr = 3'd2; rd_b_addr = 3'd3;
    want(SEL_RDA, "reinit_reg2", 32'd2);
    want(SEL_RDB, "reinit_reg3", 32'd3);
    tick();
    tick();

    tests++;
    if (dump_q.size() != 0) begin
      fails++;
      $display("FAIL dump_leftover: got %0d beats outstanding want 0", dump_q.size());
    end
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
